hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central stall/forward controller for the 5-stage MIPS pipeline, driving the other end of the stop/Tnew protocol that the F2D/D2E/E2M/M2W registers obey. It keeps its own shadow scoreboard of the in-flight instructions in E, M and W. For each entry it stores the destination register, the remaining Tnew, and the source registers. It compares these against the instruction in D (register addresses plus Tuse) and produces `stop` and per-stage forwarding selects. `stop` freezes PC/F2D and makes D2E insert a bubble.

Parameters:
- REG_W, 5, register address width
- T_W, 2, Tnew/Tuse width (0..3 cycles)
- CNT_W, 32, stall counter width (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- A1_D  in  REG_W  rs address of the instruction in D
- A2_D  in  REG_W  rt address of the instruction in D
- use_rs_D  in  1  D instruction reads rs
- use_rt_D  in  1  D instruction reads rt
- Tuse_rs_D  in  T_W  cycles until rs is needed (0 = D, 1 = E, 2 = M)
- Tuse_rt_D  in  T_W  cycles until rt is needed
- A3_D  in  REG_W  destination of the D instruction
- RegWrite_D  in  1  D instruction writes the register file
- Tnew_D  in  T_W  Tnew the instruction will have on entering E (ALU=1, DM=2, PC-link=0)
- stop  out  1  stall: hold PC/F2D, bubble into D2E
- fwd_rs_D, fwd_rt_D  out  2  D-stage operand select: 0 RF, 1 E, 2 M, 3 W
- fwd_rs_E, fwd_rt_E  out  2  E-stage operand select: 0 pipeline value, 2 M, 3 W
- fwd_rt_M  out  1  M-stage store data: 0 pipeline value, 1 W

Behaviour:
- Scoreboard entries SB_E, SB_M, SB_W. Each entry holds {vld, a3, tnew, a1, a2, u1, u2}.
- Entry match(S, r) is true when S.vld and S.a3 == r and r != 0. Register $0 never matches, so it never causes a stall or a forward.
- Clock edge with reset=1: all entries are cleared (vld=0, all fields 0).
- Clock edge with reset=0, entries update as follows:
  - SB_W <= SB_M, with tnew = sat_dec(SB_M.tnew).
  - SB_M <= SB_E, with tnew = sat_dec(SB_E.tnew).
  - If stop=1: SB_E <= bubble (all zero), mirroring the D2E clear.
  - Otherwise: SB_E <= {RegWrite_D && A3_D != 0, A3_D, Tnew_D, A1_D, A2_D, use_rs_D, use_rt_D}.
  - sat_dec(x) = x-1 if x>0, else 0.
- stall_rs = use_rs_D and one of the following holds:
  - match(SB_E, A1_D) and SB_E.tnew > Tuse_rs_D, or
  - match(SB_M, A1_D) and SB_M.tnew > Tuse_rs_D.
  - stall_rt is the same check using A2_D and Tuse_rt_D.
- stop = (stall_rs | stall_rt) & ~reset. It is combinational, with no extra latency.
- SB_W is never a stall source: its tnew is always 0.
- D-stage forward, per operand: the youngest matching stage wins (E > M > W). A select is issued only if that stage's tnew == 0; otherwise it is 0. A younger match with tnew > 0 masks older matches.
- E-stage forward uses SB_E.a1/a2 against SB_M then SB_W. It requires the source's u-flag and tnew == 0; M has priority over W.
- fwd_rt_M = SB_M.u2 and match(SB_W, SB_M.a2).
- A stalled cycle repeats identical D inputs. A stall of N cycles inserts exactly N bubbles into SB_E.
- Reset asserted mid-stall: stop is 0 in the same cycle and the scoreboard is empty on the next edge.
- All forward selects are 0 while the scoreboard is empty.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (CNT_W bits).
  - Reset sets it to 0; it increments on every edge where stop=1 and saturates at all-ones.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- `addu $3,$1,$2` then `addu $4,$3,$3`:
  - required response: stop=0.
  - The cycle the second add is in E: fwd_rs_E=fwd_rt_E=2.
- `lw $5,0($0)` then `addu $6,$5,$0` (Tuse_rs=1):
  - required response: stop=1 for exactly 1 cycle, one bubble in SB_E.
  - Then fwd_rs_E=3 (from W).
- `lw $5` then `beq $5,$0` (Tuse 0):
  - required response: stop=1 for 2 consecutive cycles.
  - Then fwd_rs_D=3.
- `jal` (A3=31, Tnew_D=0) then `jr $31`:
  - required response: stop=0 and fwd_rs_D=1.
- `addu $0,$1,$2` then `beq $0,$0`:
  - required response: stop=0, fwd_rs_D=fwd_rt_D=0.
- reset asserted during the second stall cycle of the lw/beq case:
  - required response: stop=0 immediately and all selects 0 after the edge.
  - With HAZARD_STALL_CNT_EN, stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/forward controller for the 5-stage MIPS pipeline.
//
// Keeps a shadow scoreboard of the instructions in E, M and W (destination,
// remaining Tnew, sources and their use flags). It compares these against the
// instruction in D and produces the stall request and the per-stage operand
// forwarding selects.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   A1_D, A2_D        rs/rt addresses of the D instruction
//   use_rs_D/use_rt_D D instruction reads rs/rt
//   Tuse_rs_D/_rt_D   cycles until rs/rt is needed (0 = D, 1 = E, 2 = M)
//   A3_D, RegWrite_D  destination and write enable of the D instruction
//   Tnew_D            Tnew the D instruction has on entering E
//   stop              hold PC/F2D, bubble into D2E
//   fwd_rs_D/_rt_D    D operand select: 0 RF, 1 E, 2 M, 3 W
//   fwd_rs_E/_rt_E    E operand select: 0 pipeline value, 2 M, 3 W
//   fwd_rt_M          M store data select: 0 pipeline value, 1 W
//   stall_cnt         saturating count of stalled edges (HAZARD_STALL_CNT_EN only)
//
// Optional feature macro: HAZARD_STALL_CNT_EN adds the stall_cnt output.

module hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned T_W   = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] A1_D,
  input  logic [REG_W-1:0] A2_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic [T_W-1:0]   Tuse_rs_D,
  input  logic [T_W-1:0]   Tuse_rt_D,
  input  logic [REG_W-1:0] A3_D,
  input  logic             RegWrite_D,
  input  logic [T_W-1:0]   Tnew_D,
  output logic             stop,
  output logic [1:0]       fwd_rs_D,
  output logic [1:0]       fwd_rt_D,
  output logic [1:0]       fwd_rs_E,
  output logic [1:0]       fwd_rt_E,
  output logic             fwd_rt_M
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] a3;
    logic [T_W-1:0]   tnew;
    logic [REG_W-1:0] a1;
    logic [REG_W-1:0] a2;
    logic             u1;
    logic             u2;
  } sb_entry_t;

  sb_entry_t sb_e_q, sb_e_d;
  sb_entry_t sb_m_q, sb_m_d;
  sb_entry_t sb_w_q, sb_w_d;

  logic stall_rs;
  logic stall_rt;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x != '0) ? (x - T_W'(1)) : '0;
  endfunction

  // $0 is hard-wired zero: it never matches a producer.
  function automatic logic match(input sb_entry_t s, input logic [REG_W-1:0] r);
    return s.vld && (s.a3 == r) && (r != '0);
  endfunction

  function automatic logic needs_stall(input sb_entry_t e, input sb_entry_t m,
                                       input logic use_r, input logic [REG_W-1:0] r,
                                       input logic [T_W-1:0] tuse);
    return use_r && ((match(e, r) && (e.tnew > tuse)) || (match(m, r) && (m.tnew > tuse)));
  endfunction

  // Youngest matching producer wins; if it is not ready yet it masks older ones.
  function automatic logic [1:0] fwd_d_sel(input sb_entry_t e, input sb_entry_t m,
                                           input sb_entry_t w, input logic [REG_W-1:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    if (match(e, r)) begin
      sel = (e.tnew == '0) ? 2'd1 : 2'd0;
    end else if (match(m, r)) begin
      sel = (m.tnew == '0) ? 2'd2 : 2'd0;
    end else if (match(w, r)) begin
      sel = (w.tnew == '0) ? 2'd3 : 2'd0;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input sb_entry_t m, input sb_entry_t w,
                                           input logic use_r, input logic [REG_W-1:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_r) begin
      if (match(m, r)) begin
        sel = (m.tnew == '0) ? 2'd2 : 2'd0;
      end else if (match(w, r)) begin
        sel = (w.tnew == '0) ? 2'd3 : 2'd0;
      end
    end
    return sel;
  endfunction

  // Stall and forwarding decode (combinational, same-cycle).
  always_comb begin
    stall_rs = needs_stall(sb_e_q, sb_m_q, use_rs_D, A1_D, Tuse_rs_D);
    stall_rt = needs_stall(sb_e_q, sb_m_q, use_rt_D, A2_D, Tuse_rt_D);
    stop     = (stall_rs | stall_rt) & ~reset;

    fwd_rs_D = fwd_d_sel(sb_e_q, sb_m_q, sb_w_q, A1_D);
    fwd_rt_D = fwd_d_sel(sb_e_q, sb_m_q, sb_w_q, A2_D);
    fwd_rs_E = fwd_e_sel(sb_m_q, sb_w_q, sb_e_q.u1, sb_e_q.a1);
    fwd_rt_E = fwd_e_sel(sb_m_q, sb_w_q, sb_e_q.u2, sb_e_q.a2);
    fwd_rt_M = sb_m_q.u2 && match(sb_w_q, sb_m_q.a2);
  end

  // Scoreboard advance: mirrors the D2E/E2M/M2W registers.
  always_comb begin
    sb_w_d      = sb_m_q;
    sb_w_d.tnew = sat_dec(sb_m_q.tnew);
    sb_m_d      = sb_e_q;
    sb_m_d.tnew = sat_dec(sb_e_q.tnew);
    sb_e_d      = '0;
    if (!stop) begin
      sb_e_d.vld  = RegWrite_D && (A3_D != '0);
      sb_e_d.a3   = A3_D;
      sb_e_d.tnew = Tnew_D;
      sb_e_d.a1   = A1_D;
      sb_e_d.a2   = A2_D;
      sb_e_d.u1   = use_rs_D;
      sb_e_d.u2   = use_rt_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_e_q <= '0;
      sb_m_q <= '0;
      sb_w_q <= '0;
    end else begin
      sb_e_q <= sb_e_d;
      sb_m_q <= sb_m_d;
      sb_w_q <= sb_w_d;
    end
  end

  // Fields carried for completeness of the entry but not consumed downstream.
  logic unused_fields;
  assign unused_fields = ^{sb_m_q.a1, sb_m_q.u1, sb_w_q.a1, sb_w_q.a2, sb_w_q.u1, sb_w_q.u2};

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stop && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = CNT_W[0];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences plus randomized D-stage traffic,
// checked against an instruction-level model that tracks each in-flight
// instruction's issue Tnew and its age in the pipeline.

module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] a1_d, a2_d, a3_d;
  logic       use_rs_d, use_rt_d, regwrite_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       stop;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk       (clk),
    .reset     (reset),
    .A1_D      (a1_d),
    .A2_D      (a2_d),
    .use_rs_D  (use_rs_d),
    .use_rt_D  (use_rt_d),
    .Tuse_rs_D (tuse_rs_d),
    .Tuse_rt_D (tuse_rt_d),
    .A3_D      (a3_d),
    .RegWrite_D(regwrite_d),
    .Tnew_D    (tnew_d),
    .stop      (stop),
    .fwd_rs_D  (fwd_rs_d),
    .fwd_rt_D  (fwd_rt_d),
    .fwd_rs_E  (fwd_rs_e),
    .fwd_rt_E  (fwd_rt_e),
    .fwd_rt_M  (fwd_rt_m)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: slot 0 = E, 1 = M, 2 = W. Each slot remembers the instruction as
  // issued; its current Tnew is the issue Tnew minus its age, floored at 0.
  logic       m_wr [3];
  logic [4:0] m_dst[3], m_src1[3], m_src2[3];
  logic       m_rd1[3], m_rd2[3];
  int         m_tn0[3];
  logic [31:0] m_cnt;

  function automatic int tn(int k);
    return (m_tn0[k] > k) ? m_tn0[k] - k : 0;
  endfunction

  function automatic bit hit(int k, logic [4:0] r);
    return m_wr[k] && (m_dst[k] == r) && (r != 5'd0);
  endfunction

  function automatic bit model_stall(logic [4:0] r, logic u, int tuse);
    bit s;
    s = 0;
    if (u) for (int k = 0; k < 2; k++) if (hit(k, r) && tn(k) > tuse) s = 1;
    return s;
  endfunction

  function automatic bit model_stop();
    return !reset && (model_stall(a1_d, use_rs_d, int'(tuse_rs_d)) ||
                      model_stall(a2_d, use_rt_d, int'(tuse_rt_d)));
  endfunction

  function automatic int model_fwd(logic [4:0] r, int first, bit u);
    if (!u) return 0;
    for (int k = first; k < 3; k++) if (hit(k, r)) return (tn(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  task automatic settle();
    @(negedge clk);
    check_val("stop", {31'd0, stop}, {31'd0, model_stop()});
    check_val("fwd_rs_D", {30'd0, fwd_rs_d}, model_fwd(a1_d, 0, 1'b1));
    check_val("fwd_rt_D", {30'd0, fwd_rt_d}, model_fwd(a2_d, 0, 1'b1));
    check_val("fwd_rs_E", {30'd0, fwd_rs_e}, model_fwd(m_src1[0], 1, m_rd1[0]));
    check_val("fwd_rt_E", {30'd0, fwd_rt_e}, model_fwd(m_src2[0], 1, m_rd2[0]));
    check_val("fwd_rt_M", {31'd0, fwd_rt_m}, {31'd0, m_rd2[1] && hit(2, m_src2[1])});
`ifdef HAZARD_STALL_CNT_EN
    check_val("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  task automatic advance();
    bit s;
    @(posedge clk);
    s = model_stop();
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_wr[k] = 0; m_dst[k] = 0; m_src1[k] = 0; m_src2[k] = 0;
        m_rd1[k] = 0; m_rd2[k] = 0; m_tn0[k] = 0;
      end
      m_cnt = 0;
    end else begin
      for (int k = 2; k > 0; k--) begin
        m_wr[k] = m_wr[k-1]; m_dst[k] = m_dst[k-1]; m_src1[k] = m_src1[k-1];
        m_src2[k] = m_src2[k-1]; m_rd1[k] = m_rd1[k-1]; m_rd2[k] = m_rd2[k-1];
        m_tn0[k] = m_tn0[k-1];
      end
      m_wr[0] = s ? 1'b0 : regwrite_d;
      m_dst[0] = s ? 5'd0 : a3_d;
      m_src1[0] = s ? 5'd0 : a1_d;
      m_src2[0] = s ? 5'd0 : a2_d;
      m_rd1[0] = s ? 1'b0 : use_rs_d;
      m_rd2[0] = s ? 1'b0 : use_rt_d;
      m_tn0[0] = s ? 0 : int'(tnew_d);
      if (s && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
    #1;
  endtask

  task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic ur,
                       input logic ut, input logic [1:0] tr, input logic [1:0] tt,
                       input logic [4:0] a3, input logic rw, input logic [1:0] tn_i);
    a1_d = a1; a2_d = a2; use_rs_d = ur; use_rt_d = ut; tuse_rs_d = tr; tuse_rt_d = tt;
    a3_d = a3; regwrite_d = rw; tnew_d = tn_i;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    settle();
    reset = 1'b0;
  endtask

  int  n;
  bit  held;

  initial begin
    do_reset();

    // addu $3,$1,$2 ; addu $4,$3,$3
    set_d(1, 2, 1, 1, 1, 1, 3, 1, 1); settle(); advance();
    set_d(3, 3, 1, 1, 1, 1, 4, 1, 1); settle();
    check_val("addu_addu_stop", {31'd0, stop}, 0);
    advance();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    check_val("addu_addu_fwd_rs_E", {30'd0, fwd_rs_e}, 2);
    check_val("addu_addu_fwd_rt_E", {30'd0, fwd_rt_e}, 2);
    advance();

    // lw $5,0($0) ; addu $6,$5,$0
    do_reset();
    set_d(0, 5, 1, 0, 1, 0, 5, 1, 2); settle(); advance();
    set_d(5, 0, 1, 1, 1, 1, 6, 1, 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (stop !== 1'b1) break;
      n++;
      advance();
    end
    check_val("lw_addu_stall_cycles", n, 1);
    advance();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    check_val("lw_addu_fwd_rs_E", {30'd0, fwd_rs_e}, 3);
    advance();

    // lw $5 ; beq $5,$0
    do_reset();
    set_d(0, 5, 1, 0, 1, 0, 5, 1, 2); settle(); advance();
    set_d(5, 0, 1, 1, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (stop !== 1'b1) break;
      n++;
      advance();
    end
    check_val("lw_beq_stall_cycles", n, 2);
    check_val("lw_beq_fwd_rs_D", {30'd0, fwd_rs_d}, 3);
    advance();

    // jal ; jr $31
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 31, 1, 0); settle(); advance();
    set_d(31, 0, 1, 0, 0, 0, 0, 0, 0); settle();
    check_val("jal_jr_stop", {31'd0, stop}, 0);
    check_val("jal_jr_fwd_rs_D", {30'd0, fwd_rs_d}, 1);
    advance();

    // addu $0,$1,$2 ; beq $0,$0
    do_reset();
    set_d(1, 2, 1, 1, 1, 1, 0, 1, 1); settle(); advance();
    set_d(0, 0, 1, 1, 0, 0, 0, 0, 0); settle();
    check_val("zero_reg_stop", {31'd0, stop}, 0);
    check_val("zero_reg_fwd_rs_D", {30'd0, fwd_rs_d}, 0);
    check_val("zero_reg_fwd_rt_D", {30'd0, fwd_rt_d}, 0);
    advance();

    // Reset during the second stall cycle of lw/beq
    do_reset();
    set_d(0, 5, 1, 0, 1, 0, 5, 1, 2); settle(); advance();
    set_d(5, 0, 1, 1, 0, 0, 0, 0, 0); settle(); advance();
    settle();
    check_val("mid_stall_stop_before", {31'd0, stop}, 1);
    reset = 1'b1;
    #1;
    check_val("mid_stall_stop_reset", {31'd0, stop}, 0);
    advance();
    settle();
    check_val("mid_stall_fwd_rs_D", {30'd0, fwd_rs_d}, 0);
    check_val("mid_stall_fwd_rt_D", {30'd0, fwd_rt_d}, 0);
    check_val("mid_stall_fwd_rs_E", {30'd0, fwd_rs_e}, 0);
    check_val("mid_stall_fwd_rt_M", {31'd0, fwd_rt_m}, 0);
`ifdef HAZARD_STALL_CNT_EN
    check_val("mid_stall_cnt", stall_cnt, 0);
`endif
    reset = 1'b0;
    settle();
    check_val("after_reset_stop", {31'd0, stop}, 0);
    advance();

    // Random traffic on a small register set; D inputs held while stalled.
    held = 0;
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 40) == 0);
      if (!held) begin
        set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)));
      end
      settle();
      held = model_stop();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
